// File: rtl/cnn_infer_ctrl.sv
// Board-level CNN inference controller: button debounce, image select, pixel-address streaming,
// result latch and timeout. Optional macro CNN_ERR_BLINK_EN blinks the LEDs while in error.
module cnn_infer_ctrl #(
  parameter int unsigned NUM_BTN      = 2,
  parameter int unsigned DB_CYCLES    = 1000000,
  parameter int unsigned IX           = 28,
  parameter int unsigned IY           = 28,
  parameter int unsigned IMG_BW       = 2,
  parameter int unsigned CLS_BW       = 3,
  parameter int unsigned LED_W        = 3,
  parameter int unsigned TIMEOUT      = 1048576,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BTN-1:0]          i_btn,
  output logic                        o_cnn_start,
  output logic [IMG_BW-1:0]           o_img_sel,
  output logic                        o_pix_valid,
  output logic [$clog2(IX*IY)-1:0]    o_pix_addr,
  input  logic                        i_pix_ready,
  input  logic                        i_cnn_valid,
  input  logic [CLS_BW-1:0]           i_cnn_class,
  output logic [LED_W-1:0]            o_led,
  output logic                        o_busy,
  output logic                        o_err
);

  localparam int unsigned NumPix = IX * IY;
  localparam int unsigned AddrW  = $clog2(NumPix);
  localparam int unsigned DbW    = $clog2(DB_CYCLES);
  localparam int unsigned ToW    = $clog2(TIMEOUT);
  localparam int unsigned ExtW   = (LED_W > CLS_BW) ? LED_W : CLS_BW;

  typedef enum logic [2:0] {StIdle, StStream, StWait, StShow, StErr} state_e;

  logic [NUM_BTN-1:0] sync1_q, sync2_q, press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    logic           stable_q;
    logic [DbW-1:0] cnt_q;
    logic           expire;

    assign expire   = (sync2_q[b] != stable_q) && (cnt_q == DbW'(DB_CYCLES - 1));
    // Press fires on the cycle the stable level is about to rise.
    assign press[b] = expire && !stable_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else if (sync2_q[b] == stable_q) begin
        cnt_q <= '0;
      end else if (expire) begin
        stable_q <= sync2_q[b];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + DbW'(1);
      end
    end
  end

  if (NUM_BTN > 2) begin : g_unused_btn
    logic unused_press;
    assign unused_press = ^press[NUM_BTN-1:2];
  end

  logic start_press, next_press;
  assign start_press = press[0];
  assign next_press  = press[1];

  logic [ExtW-1:0] cls_ext;
  assign cls_ext = ExtW'(i_cnn_class);

  state_e            state_q, state_d;
  logic [IMG_BW-1:0] img_q, img_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              busy_q, valid_q;

`ifdef CNN_ERR_BLINK_EN
  localparam int unsigned BlW = $clog2(BLINK_CYCLES);
  logic [BlW-1:0] blink_q, blink_d;
`endif

  always_comb begin
    state_d  = state_q;
    img_d    = img_q;
    addr_d   = addr_q;
    to_cnt_d = to_cnt_q;
    led_d    = led_q;
    err_d    = err_q;
    start_d  = 1'b0;
    case (state_q)
      StIdle, StShow, StErr: begin
        if (next_press) img_d = img_q + IMG_BW'(1);
        if (start_press) begin
          state_d = StStream;
          start_d = 1'b1;
          err_d   = 1'b0;
          addr_d  = '0;
        end
      end
      StStream: begin
        if (i_pix_ready) begin
          if (addr_q == AddrW'(NumPix - 1)) begin
            state_d  = StWait;
            addr_d   = '0;
            to_cnt_d = '0;
          end else begin
            addr_d = addr_q + AddrW'(1);
          end
        end
      end
      StWait: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        // A result arriving on the last allowed cycle still counts.
        if (i_cnn_valid) begin
          state_d = StShow;
          led_d   = cls_ext[LED_W-1:0];
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          state_d = StErr;
          err_d   = 1'b1;
          led_d   = '1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef CNN_ERR_BLINK_EN
    blink_d = '0;
    if (state_q == StErr && state_d == StErr) begin
      if (blink_q == BlW'(BLINK_CYCLES - 1)) begin
        led_d = ~led_q;
      end else begin
        blink_d = blink_q + BlW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      img_q    <= '0;
      addr_q   <= '0;
      to_cnt_q <= '0;
      led_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      addr_q   <= addr_d;
      to_cnt_q <= to_cnt_d;
      led_q    <= led_d;
      err_q    <= err_d;
      start_q  <= start_d;
      busy_q   <= (state_d == StStream) || (state_d == StWait);
      valid_q  <= (state_d == StStream);
    end
  end

`ifdef CNN_ERR_BLINK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_d;
  end
`endif

  assign o_cnn_start = start_q;
  assign o_img_sel   = img_q;
  assign o_pix_valid = valid_q;
  assign o_pix_addr  = addr_q;
  assign o_led       = led_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_cnn_infer_ctrl.sv
// Self-checking bench for cnn_infer_ctrl with small debounce, image and timeout parameters.
module tb_cnn_infer_ctrl;

  localparam int unsigned NPix = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] i_btn;
  logic       o_cnn_start;
  logic [1:0] o_img_sel;
  logic       o_pix_valid;
  logic [3:0] o_pix_addr;
  logic       i_pix_ready;
  logic       i_cnn_valid;
  logic [2:0] i_cnn_class;
  logic [2:0] o_led;
  logic       o_busy;
  logic       o_err;

  cnn_infer_ctrl #(
    .NUM_BTN(2), .DB_CYCLES(4), .IX(4), .IY(4), .IMG_BW(2), .CLS_BW(3), .LED_W(3),
    .TIMEOUT(32), .BLINK_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn), .o_cnn_start(o_cnn_start), .o_img_sel(o_img_sel),
    .o_pix_valid(o_pix_valid), .o_pix_addr(o_pix_addr), .i_pix_ready(i_pix_ready),
    .i_cnn_valid(i_cnn_valid), .i_cnn_class(i_cnn_class), .o_led(o_led), .o_busy(o_busy),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         mode;     // 0: ready always, 1: every 2nd cycle, 2: every 4th cycle
    int         delay;    // WAIT cycle carrying the result, -1 for none
    logic [2:0] cls;
    logic       nxt;      // press next during STREAM
    logic [2:0] exp_led;
    logic       exp_err;
    int         exp_cyc;  // cycles from first STREAM cycle to last acceptance, inclusive
  } frame_t;

  frame_t     frames[5];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] img_m;
  logic [2:0] led_m;
  logic [3:0] addr_sb[$];
  logic [2:0] led_sb[$];
  int         next_exp[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, o_cnn_start, 0);
    chk({tag, "_img"}, o_img_sel, 0);
    chk({tag, "_valid"}, o_pix_valid, 0);
    chk({tag, "_addr"}, o_pix_addr, 0);
    chk({tag, "_led"}, o_led, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic pulse_btn(input int b);
    i_btn[b] = 1'b1;
    repeat (6) @(negedge clk);
    i_btn[b] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic start_frame();
    int n = 0;
    i_pix_ready = 1'b0;
    i_btn[0]    = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!o_cnn_start && n < 12);
    i_btn[0] = 1'b0;
    chk("start_latency", n, 6);
    chk("start_addr", o_pix_addr, 0);
    chk("start_err", o_err, 0);
    chk("start_busy", o_busy, 1);
    chk("start_img", o_img_sel, img_m);
    chk("start_led_hold", o_led, led_m);
    for (int i = 0; i < NPix; i++) addr_sb.push_back(4'(i));
  endtask

  task automatic run_stream(input int mode, input logic nxt, input int exp_cyc);
    int c = 0;
    int last = -1;
    while (addr_sb.size() > 0 && c < 200) begin
      if (nxt && c == 0) i_btn[1] = 1'b1;
      if (c == 8) i_btn[1] = 1'b0;
      i_pix_ready = (mode == 0) || (c % ((mode == 1) ? 2 : 4) == 0);
      if (c == 1) chk("start_pulse_width", o_cnn_start, 0);
      if (i_pix_ready) begin
        chk("pix_valid", o_pix_valid, 1);
        chk("pix_addr", o_pix_addr, addr_sb.pop_front());
        last = c;
      end
      @(negedge clk);
      c++;
    end
    i_pix_ready = 1'b0;
    i_btn[1]    = 1'b0;
    chk("stream_budget", addr_sb.size(), 0);
    addr_sb.delete();
    chk("stream_cycles", last + 1, exp_cyc);
    chk("wait_valid", o_pix_valid, 0);
    chk("wait_addr", o_pix_addr, 0);
    chk("wait_busy", o_busy, 1);
    chk("wait_img", o_img_sel, img_m);
    chk("wait_led_hold", o_led, led_m);
  endtask

  task automatic run_wait(input frame_t f);
    int w = 0;
    bit done = 0;
    while (!done && w < 100) begin
      i_cnn_valid = (w == f.delay);
      i_cnn_class = f.cls;
      if (i_cnn_valid) led_sb.push_back(f.exp_led);
      @(negedge clk);
      w++;
      i_cnn_valid = 1'b0;
      if (led_sb.size() > 0) begin
        chk("result_led", o_led, led_sb.pop_front());
        chk("result_busy", o_busy, 0);
        chk("result_cycle", w, f.delay + 1);
        done = 1;
      end else if (o_err) begin
        chk("err_cycle", w, 32);
        chk("err_led", o_led, 7);
        chk("err_busy", o_busy, 0);
        done = 1;
      end
    end
    chk("frame_outcome_err", o_err, f.exp_err);
    if (!f.exp_err) begin
      i_cnn_valid = 1'b1;
      i_cnn_class = f.cls + 3'd1;
      @(negedge clk);
      i_cnn_valid = 1'b0;
      chk("stray_valid_led", o_led, f.exp_led);
      chk("stray_valid_busy", o_busy, 0);
    end
    led_m = f.exp_led;
  endtask

  initial begin
    int first = -1;
    int cnt = 0;

    frames[0] = '{1, 10, 3'd5, 1'b0, 3'd5, 1'b0, 31};
    frames[1] = '{0, -1, 3'd0, 1'b0, 3'd7, 1'b1, 16};
    frames[2] = '{0, 31, 3'd3, 1'b0, 3'd3, 1'b0, 16};
    frames[3] = '{2, 0, 3'd6, 1'b1, 3'd6, 1'b0, 61};
    frames[4] = '{0, -1, 3'd0, 1'b0, 3'd7, 1'b1, 16};
    next_exp  = '{1, 2, 3, 0, 1};

    reset       = 1'b1;
    i_btn       = 2'b00;
    i_pix_ready = 1'b0;
    i_cnn_valid = 1'b0;
    i_cnn_class = 3'd0;
    img_m       = 2'd0;
    led_m       = 3'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Bouncy start: 1-1-0-0 then held high 10 cycles.
    for (int n = 0; n < 24; n++) begin
      i_btn[0] = (n < 2) || (n >= 4 && n < 14);
      @(negedge clk);
      if (o_cnn_start) begin
        cnt++;
        if (first < 0) first = n - 3;
      end
    end
    chk("bounce_latency", first, 6);
    chk("bounce_count", cnt, 1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      pulse_btn(1);
      chk("next_img", o_img_sel, next_exp[i]);
    end
    img_m = 2'd1;

    for (int i = 0; i < 5; i++) begin
      start_frame();
      run_stream(frames[i].mode, frames[i].nxt, frames[i].exp_cyc);
      run_wait(frames[i]);
    end

    // Asynchronous reset in the middle of a frame.
    start_frame();
    for (int c = 0; c < 7; c++) begin
      i_pix_ready = 1'b1;
      chk("pre_reset_addr", o_pix_addr, addr_sb.pop_front());
      @(negedge clk);
    end
    chk("mid_frame_addr", o_pix_addr, 7);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    addr_sb.delete();
    i_pix_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    img_m = 2'd0;
    led_m = 3'd0;
    repeat (2) @(negedge clk);
    start_frame();
    run_stream(0, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnn_infer_ctrl.md
Name: cnn_infer_ctrl

Overview:
Parametrised board-level inference controller that replaces the single-button debounce front end of the CNN top.
- Debounces NUM_BTN raw buttons and selects one of 2^IMG_BW stored images.
- Streams that image's pixel addresses into the CNN with a valid/ready handshake, then waits for the classification result.
- Latches the result onto LEDs, and flags an error if the CNN does not answer within a timeout.

Parameters:
- NUM_BTN, 2, number of raw buttons (>=2); bit0 = start, bit1 = next image, higher bits unused.
- DB_CYCLES, 1000000, consecutive stable cycles needed to accept a button level.
- IX, 28, image width in pixels.
- IY, 28, image height in pixels.
- IMG_BW, 2, image-select width.
- CLS_BW, 3, CNN class/alpha width.
- LED_W, 3, LED output width.
- TIMEOUT, 1048576, maximum cycles spent in WAIT before error.
- BLINK_CYCLES, 25000000, half-period of the error blink (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_btn  in  NUM_BTN  raw, unsynchronised buttons, active-high
- o_cnn_start  out  1  one-cycle pulse marking the start of a frame
- o_img_sel  out  IMG_BW  currently selected image
- o_pix_valid  out  1  pixel address valid
- o_pix_addr  out  clog2(IX*IY)  pixel address, row-major
- i_pix_ready  in  1  CNN accepts the current address
- i_cnn_valid  in  1  result strobe from the CNN
- i_cnn_class  in  CLS_BW  result class, sampled when i_cnn_valid=1
- o_led  out  LED_W  displayed result
- o_busy  out  1  high in STREAM or WAIT
- o_err  out  1  timeout flag

Behaviour:
- Reset (asynchronous, active-high): every output is 0, the FSM is in IDLE, and all counters and synchronisers are cleared.
- Debounce, per button:
  - Two-flop synchroniser, then a stable-level register plus a counter.
  - The counter clears whenever the synchronised level equals the stable level.
  - Otherwise it increments; when it reaches DB_CYCLES-1 the stable level flips.
  - A rising edge of the stable level produces a one-cycle press pulse.
  - Latency from a clean raw edge to the pulse is 2+DB_CYCLES cycles.
- Next-image press (bit1):
  - Honoured only in IDLE, SHOW or ERR; ignored in STREAM and WAIT.
  - Increments o_img_sel modulo 2^IMG_BW (wraps from max to 0).
  - Does not change state.
- Start press (bit0): honoured in IDLE, SHOW or ERR; ignored in STREAM and WAIT.
- If start and next are pressed in the same cycle, o_img_sel increments first and the start uses the new image.
- FSM states IDLE, STREAM, WAIT, SHOW, ERR:
  - IDLE/SHOW/ERR -> STREAM on a start press.
    - o_cnn_start pulses in the first STREAM cycle; o_pix_addr=0 and o_err clears.
    - o_led keeps its old value until a new result arrives.
  - STREAM:
    - o_pix_valid=1 every cycle.
    - o_pix_addr increments only on valid&&ready and holds while i_pix_ready=0.
    - Acceptance of address IX*IY-1 -> WAIT; o_pix_valid=0 from the next cycle, and o_pix_addr returns to 0.
  - WAIT:
    - The timeout counter starts at 0.
    - On i_cnn_valid: o_led = i_cnn_class, zero-extended or truncated to LED_W, visible the next cycle -> SHOW.
    - If the counter reaches TIMEOUT-1 without valid -> ERR with o_err=1 and o_led all ones.
    - If valid and expiry occur in the same cycle, valid wins and the FSM goes to SHOW.
  - SHOW: holds o_led until the next start.
  - ERR: holds o_err=1 until the next start.
- i_cnn_valid outside WAIT is ignored.
- o_busy is registered with the state: high exactly in STREAM and WAIT.
- Reset mid-frame: returns to IDLE immediately; no partial result is latched.

Optional Feature:
CNN_ERR_BLINK_EN
- Defined: in ERR, o_led toggles between all ones and all zeros every BLINK_CYCLES cycles, starting at all ones. The blink counter clears on leaving ERR.
- Undefined: o_led is a static all ones in ERR, and no blink counter is built.

Test Plan:
All scenarios use DB_CYCLES=4, IX=IY=4, TIMEOUT=32, IMG_BW=2.
1. Raw bit0 bounces 1-0-1 with 2-cycle pulses, then holds high 10 cycles -> exactly one o_cnn_start, appearing 6 cycles after the final rising edge.
2. Press next 5 times from reset -> o_img_sel sequence 1, 2, 3, 0, 1. A next press during STREAM leaves o_img_sel unchanged.
3. Start with i_pix_ready toggling 1,0,1,0... -> addresses 0..15 each accepted once, in order; 16 accepts in 31 cycles; then WAIT with o_busy=1.
4. In WAIT, drive i_cnn_valid with class 5 after 10 cycles -> o_led=3'b101 the next cycle, SHOW, o_busy=0. A stray valid with class 2 in SHOW leaves o_led=5.
5. No i_cnn_valid -> o_err=1 and o_led=3'b111 exactly 32 cycles after entering WAIT. Valid asserted on cycle 31 instead -> SHOW, o_err stays 0. Start from ERR clears o_err and restarts at addr 0.
6. Assert reset mid-STREAM at addr 7 -> all outputs 0 asynchronously. After release, a start streams from addr 0.
